ahb_icache: RTL and testbench
=============================

// Module: ahb_icache
// PURPOSE
// Direct-mapped, read-only AHB-Lite instruction cache between CPU (upstream slave side) and memory
// (downstream master side). Hits: zero wait states. Misses: INCR4 line fill from memory, then serve word.
// PARAMETERS
// ADDR_W      32  address width (byte address)
// DATA_W      32  bus data width; fixed 32
// NUM_LINES   16  cache lines, power of 2; index = haddr[4+:log2(NUM_LINES)]
// LINE_WORDS   4  words per line (128-bit line); offset = haddr[3:2]; fixed 4 (INCR4)
// PORTS
// hclk        in   1      clock, shared by both sides
// hrst        in   1      asynchronous reset, active-low
// s_hsel      in   1      upstream slave select
// s_haddr     in   32     upstream address
// s_htrans    in   2      upstream transfer type (IDLE=0,BUSY=1,NONSEQ=2,SEQ=3)
// s_hwrite    in   1      upstream write flag
// s_hsize     in   3      upstream transfer size
// s_hburst    in   3      upstream burst type (ignored; each beat handled singly)
// s_hready    in   1      upstream bus HREADY (system loops back s_hreadyout)
// s_hreadyout out  1      upstream ready/wait
// s_hresp     out  1      upstream response (0=OKAY,1=ERROR)
// s_hrdata    out  32     upstream read data
// m_haddr     out  32     downstream address
// m_htrans    out  2      downstream transfer type
// m_hwrite    out  1      downstream write flag; always 0
// m_hsize     out  3      downstream size; always 3'b010
// m_hburst    out  3      downstream burst; 3'b011 (INCR4) during fill, else 0
// m_hwdata    out  32     downstream write data; always 0
// m_hrdata    in   32     downstream read data
// m_hready    in   1      downstream ready
// m_hresp     in   1      downstream response
// BEHAVIOUR
// - Reset (hrst=0, async): all valid bits 0; FSM=IDLE; s_hreadyout=1, s_hresp=0, s_hrdata=0, m_htrans=IDLE, m_haddr=0, m_hburst=0.
// - Reset mid-fill: burst abandoned immediately (m_htrans=IDLE), line not validated.
// - Address phase accepted when s_hsel & s_hready & s_htrans[1]; addr/type registered for data phase.
// - Tag = haddr[31:4+log2(NUM_LINES)]; line store: tag, valid, LINE_WORDS x 32b data.
// - FSM: IDLE -> LOOKUP (data phase) -> hit: IDLE/LOOKUP; miss: FILL -> RESPOND; error: ERR1 -> ERR2.
// - Hit: in data-phase cycle s_hreadyout=1, s_hresp=0, s_hrdata=line word[offset] (combinational from registered addr).
//   Back-to-back hits run at one per cycle.
// - Miss (cycle D): s_hreadyout=0. D+1: m_htrans=NONSEQ, m_haddr=addr&~0xF, m_hburst=INCR4.
//   Each following beat: m_htrans=SEQ, m_haddr+=4; beats advance only when m_hready=1; data captured
//   into line word i on each data phase with m_hready=1. After last beat m_htrans=IDLE; line, tag, valid written.
//   Next cycle (RESPOND): s_hreadyout=1, s_hrdata=requested word. Zero-wait memory: 6 wait cycles (D..D+5).
//   Critical word not forwarded early; pending upstream address held by master, accepted in RESPOND.
// - Fill replaces line at index regardless of previous contents (no write-back; read-only cache).
// - Upstream write or s_hsize!=3'b010: no memory access; two-cycle ERROR (ERR1: hreadyout=0,hresp=1;
//   ERR2: hreadyout=1,hresp=1).
// - m_hresp=1 during fill: drive m_htrans=IDLE next cycle, discard line (valid stays 0), upstream ERROR two-cycle.
// - IDLE/BUSY upstream or s_hsel=0: OKAY, zero wait, no state change.
// - s_hrdata outside a valid read response: hold last value.
// TESTING
// - Reset: hrst=0 -> s_hreadyout=1, s_hresp=0, m_htrans=0; every first read is a miss.
// - Cold miss read 0x0000_0104, zero-wait mem (word at A = A) -> NONSEQ 0x100, SEQ 0x104/0x108/0x10C, INCR4; s_hrdata=0x104 after 6 waits.
// - Then read 0x100,0x108,0x10C back-to-back -> hits, zero waits, data 0x100/0x108/0x10C, m_htrans stays IDLE.
// - Conflict: read 0x0000_0204 (same index 0) -> miss refill, then 0x104 misses again.
// - Memory inserting 2 wait states per beat -> addresses held while m_hready=0, correct data, s_hreadyout low until done.
// - Upstream write to 0x100 -> ERROR two-cycle, m_htrans=IDLE; fill with m_hresp=1 -> upstream ERROR, next read same line misses.

Source files
------------

// File: rtl/ahb_icache.sv
// Direct-mapped, read-only AHB-Lite instruction cache.
// Hits return data with zero wait states. Misses refill the whole line with an INCR4 burst,
// then return the requested word. Writes and non-word reads get a two-cycle ERROR response.
module ahb_icache #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic              hclk,
    input  logic              hrst,
    input  logic              s_hsel,
    input  logic [ADDR_W-1:0] s_haddr,
    input  logic [1:0]        s_htrans,
    input  logic              s_hwrite,
    input  logic [2:0]        s_hsize,
    input  logic [2:0]        s_hburst,
    input  logic              s_hready,
    output logic              s_hreadyout,
    output logic              s_hresp,
    output logic [DATA_W-1:0] s_hrdata,
    output logic [ADDR_W-1:0] m_haddr,
    output logic [1:0]        m_htrans,
    output logic              m_hwrite,
    output logic [2:0]        m_hsize,
    output logic [2:0]        m_hburst,
    output logic [DATA_W-1:0] m_hwdata,
    input  logic [DATA_W-1:0] m_hrdata,
    input  logic              m_hready,
    input  logic              m_hresp
);

    localparam int unsigned IW = $clog2(NUM_LINES);
    localparam int unsigned TW = ADDR_W - 4 - IW;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, RESPOND, ERR1, ERR2} state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] req_addr;
    logic [TW-1:0]     tag_mem  [NUM_LINES];
    logic [DATA_W-1:0] data_mem [NUM_LINES*LINE_WORDS];
    logic [NUM_LINES-1:0] valid;

    // Fill sequencing: beat_a = next address-phase beat, beat_d = beat in data phase
    logic       issuing;
    logic       dphase;
    logic [1:0] beat_a;
    logic [1:0] beat_d;

    logic [DATA_W-1:0] hold_q;
    logic              resp_valid;

    logic [IW-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic [1:0]    req_off;
    logic          hit;
    logic          accept;
    logic          bad_req;
    logic [DATA_W-1:0] rd_word;

    assign req_idx = req_addr[4 +: IW];
    assign req_tag = req_addr[ADDR_W-1 -: TW];
    assign req_off = req_addr[3:2];
    assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign rd_word = data_mem[{req_idx, req_off}];
    assign accept  = s_hsel && s_hready && s_htrans[1] && s_hreadyout;
    assign bad_req = s_hwrite || (s_hsize != 3'b010);

    assign m_hwrite = 1'b0;
    assign m_hsize  = 3'b010;
    assign m_hwdata = '0;

    logic unused_ok;
    assign unused_ok = ^{s_hburst, s_htrans[0], req_addr[1:0]};

    // State register
    always_ff @(posedge hclk or negedge hrst) begin
        if (!hrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESPOND, ERR2: state_d = accept ? (bad_req ? ERR1 : LOOKUP) : IDLE;
            LOOKUP: begin
                if (hit) state_d = accept ? (bad_req ? ERR1 : LOOKUP) : IDLE;
                else     state_d = FILL;
            end
            FILL: begin
                if (dphase && m_hresp)                          state_d = ERR1;
                else if (dphase && m_hready && beat_d == 2'd3)  state_d = RESPOND;
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
    end

    // Output decode for both bus sides
    always_comb begin
        s_hreadyout = 1'b1;
        s_hresp     = 1'b0;
        resp_valid  = 1'b0;
        m_htrans    = 2'b00;
        m_haddr     = '0;
        m_hburst    = 3'b000;
        case (state_q)
            LOOKUP: begin
                s_hreadyout = hit;
                resp_valid  = hit;
            end
            FILL: begin
                s_hreadyout = 1'b0;
                if (issuing) begin
                    m_htrans = (beat_a == 2'd0) ? 2'b10 : 2'b11;
                    m_haddr  = {req_addr[ADDR_W-1:4], beat_a, 2'b00};
                    m_hburst = 3'b011;
                end
            end
            RESPOND: resp_valid = 1'b1;
            ERR1: begin
                s_hreadyout = 1'b0;
                s_hresp     = 1'b1;
            end
            ERR2:    s_hresp = 1'b1;
            default: ;
        endcase
        s_hrdata = resp_valid ? rd_word : hold_q;
    end

    // Registered request address and last returned read data
    always_ff @(posedge hclk or negedge hrst) begin
        if (!hrst) begin
            req_addr <= '0;
            hold_q   <= '0;
        end else begin
            if (accept) req_addr <= s_haddr;
            hold_q <= s_hrdata;
        end
    end

    // Fill beat counters and valid bits; the line is invalidated at miss time so an
    // abandoned or errored fill can never leave a half-written line marked valid
    always_ff @(posedge hclk or negedge hrst) begin
        if (!hrst) begin
            valid   <= '0;
            issuing <= 1'b0;
            dphase  <= 1'b0;
            beat_a  <= 2'd0;
            beat_d  <= 2'd0;
        end else if (state_q == LOOKUP && !hit) begin
            valid[req_idx] <= 1'b0;
            issuing        <= 1'b1;
            dphase         <= 1'b0;
            beat_a         <= 2'd0;
        end else if (state_q == FILL && m_hready && !(dphase && m_hresp)) begin
            if (issuing) begin
                dphase <= 1'b1;
                beat_d <= beat_a;
                beat_a <= beat_a + 2'd1;
                if (beat_a == 2'd3) issuing <= 1'b0;
            end else begin
                dphase <= 1'b0;
            end
            if (dphase && beat_d == 2'd3) valid[req_idx] <= 1'b1;
        end
    end

    // Tag and data storage
    always_ff @(posedge hclk) begin
        if (state_q == LOOKUP && !hit) tag_mem[req_idx] <= req_tag;
        if (state_q == FILL && m_hready && dphase && !m_hresp)
            data_mem[{req_idx, beat_d}] <= m_hrdata;
    end

endmodule

// File: tb/tb_ahb_icache.sv
// Directed testbench for ahb_icache with a behavioural downstream memory (word at A reads A).
module tb_ahb_icache;

    logic        hclk;
    logic        hrst;
    logic        s_hsel;
    logic [31:0] s_haddr;
    logic [1:0]  s_htrans;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [2:0]  s_hburst;
    logic        s_hready;
    logic        s_hreadyout;
    logic        s_hresp;
    logic [31:0] s_hrdata;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [2:0]  m_hburst;
    logic [31:0] m_hwdata;
    logic [31:0] m_hrdata;
    logic        m_hready;
    logic        m_hresp;

    int n_checks = 0;
    int n_errors = 0;

    ahb_icache #(.ADDR_W(32), .DATA_W(32), .NUM_LINES(16), .LINE_WORDS(4)) dut (
        .hclk(hclk), .hrst(hrst),
        .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
        .s_hsize(s_hsize), .s_hburst(s_hburst), .s_hready(s_hready),
        .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
        .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
        .m_hburst(m_hburst), .m_hwdata(m_hwdata), .m_hrdata(m_hrdata),
        .m_hready(m_hready), .m_hresp(m_hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    assign s_hready = s_hreadyout;

    // Memory model: ws wait states per data phase, optional two-cycle error at err_addr
    int unsigned ws;
    logic        err_en;
    logic [31:0] err_addr;
    logic        dp_active;
    logic        errph;
    logic [31:0] dp_addr;
    int unsigned wcnt;

    always_comb begin
        m_hready = 1'b1;
        m_hresp  = 1'b0;
        m_hrdata = '0;
        if (dp_active) begin
            m_hrdata = dp_addr;
            if (wcnt != 0) m_hready = 1'b0;
            else if (err_en && dp_addr == err_addr) begin
                m_hresp  = 1'b1;
                m_hready = errph;
            end
        end
    end

    always @(posedge hclk or negedge hrst) begin
        if (!hrst) begin
            dp_active <= 1'b0;
            errph     <= 1'b0;
            wcnt      <= 0;
            dp_addr   <= '0;
        end else if (dp_active && wcnt != 0) begin
            wcnt <= wcnt - 1;
        end else if (m_hready) begin
            errph <= 1'b0;
            if (m_htrans[1]) begin
                dp_active <= 1'b1;
                dp_addr   <= m_haddr;
                wcnt      <= ws;
            end else begin
                dp_active <= 1'b0;
            end
        end else if (m_hresp) begin
            errph <= 1'b1;
        end
    end

    // Bus monitor: accepted downstream address phases, and address stability under stall
    logic [31:0] acc_addr[$];
    logic [4:0]  acc_ctl[$];
    logic        stall_pend;
    logic [31:0] stall_addr;
    int          hold_err = 0;

    always @(posedge hclk) begin
        if (hrst) begin
            if (m_hready && m_htrans[1]) begin
                acc_addr.push_back(m_haddr);
                acc_ctl.push_back({m_hburst, m_htrans});
            end
            if (stall_pend && m_htrans[1] && m_haddr != stall_addr) hold_err <= hold_err + 1;
            stall_pend <= m_htrans[1] && !m_hready;
            stall_addr <= m_haddr;
        end else begin
            stall_pend <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        acc_addr.delete();
        acc_ctl.delete();
    endtask

    // One upstream transfer; called #1 after a rising edge with the slave ready
    task automatic do_read(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                           output logic [31:0] data, output logic resp, output int waits);
        logic timed_out;
        timed_out = 1'b0;
        s_hsel = 1'b1; s_haddr = a; s_htrans = 2'b10; s_hwrite = wr; s_hsize = sz;
        @(posedge hclk); #1;
        s_hsel = 1'b0; s_htrans = 2'b00; s_hwrite = 1'b0; s_hsize = 3'b010;
        waits = 0;
        forever begin
            @(negedge hclk);
            if (s_hreadyout) break;
            waits++;
            if (waits >= 60) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge hclk); #1;
        end
        if (timed_out) check("timeout", 32'd1, 32'd0);
        data = s_hrdata;
        resp = s_hresp;
        @(posedge hclk); #1;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp_data,
                          input int exp_waits);
        logic [31:0] d;
        logic        r;
        int          w;
        do_read(a, 1'b0, 3'b010, d, r, w);
        check({tag, "_data"}, d, exp_data);
        check({tag, "_resp"}, {31'd0, r}, 32'd0);
        check({tag, "_waits"}, w, exp_waits);
    endtask

    task automatic err_chk(input string tag, input logic [31:0] a, input logic wr,
                           input logic [2:0] sz, input int exp_waits);
        logic [31:0] d;
        logic        r;
        int          w;
        do_read(a, wr, sz, d, r, w);
        check({tag, "_resp"}, {31'd0, r}, 32'd1);
        check({tag, "_waits"}, w, exp_waits);
    endtask

    task automatic check_fill(input string tag, input logic [31:0] base);
        check({tag, "_beats"}, acc_addr.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < acc_addr.size()) begin
                check({tag, "_addr"}, acc_addr[i], base + 32'(4 * i));
                check({tag, "_ctl"}, {27'd0, acc_ctl[i]}, (i == 0) ? 32'h0E : 32'h0F);
            end
        end
    endtask

    logic [31:0] hit_addrs [3];

    initial begin
        hrst = 1'b1;
        s_hsel = 1'b0; s_haddr = '0; s_htrans = 2'b00; s_hwrite = 1'b0;
        s_hsize = 3'b010; s_hburst = 3'b000;
        ws = 0; err_en = 1'b0; err_addr = '0;
        #1 hrst = 1'b0;
        #2;
        check("rst_hreadyout", {31'd0, s_hreadyout}, 32'd1);
        check("rst_hresp", {31'd0, s_hresp}, 32'd0);
        check("rst_hrdata", s_hrdata, 32'd0);
        check("rst_mtrans", {30'd0, m_htrans}, 32'd0);
        check("rst_maddr", m_haddr, 32'd0);
        check("rst_mburst", {29'd0, m_hburst}, 32'd0);
        #10 hrst = 1'b1;
        @(posedge hclk); #1;

        // Cold miss: six wait states, INCR4 from the aligned line base
        clear_mon();
        rd_chk("cold", 32'h0000_0104, 32'h0000_0104, 6);
        check_fill("cold_fill", 32'h0000_0100);

        // Back-to-back hits at one per cycle, memory untouched
        clear_mon();
        hit_addrs[0] = 32'h100; hit_addrs[1] = 32'h108; hit_addrs[2] = 32'h10C;
        s_hsel = 1'b1; s_htrans = 2'b10; s_haddr = hit_addrs[0];
        @(posedge hclk); #1;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) s_haddr = hit_addrs[i+1];
            else begin s_hsel = 1'b0; s_htrans = 2'b00; end
            @(negedge hclk);
            check("b2b_ready", {31'd0, s_hreadyout}, 32'd1);
            check("b2b_data", s_hrdata, hit_addrs[i]);
            check("b2b_mtrans", {30'd0, m_htrans}, 32'd0);
            @(posedge hclk); #1;
        end
        check("b2b_nofill", acc_addr.size(), 32'd0);

        // Conflict on index 0 evicts and refills
        clear_mon();
        rd_chk("conf", 32'h0000_0204, 32'h0000_0204, 6);
        check_fill("conf_fill", 32'h0000_0200);
        rd_chk("conf_back", 32'h0000_0104, 32'h0000_0104, 6);

        // Two wait states per beat: 2 + 4*3 upstream waits, addresses held while stalled
        clear_mon();
        ws = 2;
        rd_chk("ws", 32'h0000_0318, 32'h0000_0318, 14);
        check_fill("ws_fill", 32'h0000_0310);
        check("ws_addr_hold", hold_err, 32'd0);
        ws = 0;
        rd_chk("ws_hit", 32'h0000_031C, 32'h0000_031C, 0);

        // Write and byte read produce the two-cycle error without memory traffic
        clear_mon();
        err_chk("wr_err", 32'h0000_0100, 1'b1, 3'b010, 1);
        err_chk("size_err", 32'h0000_0104, 1'b0, 3'b000, 1);
        check("err_nofill", acc_addr.size(), 32'd0);
        rd_chk("after_err_hit", 32'h0000_0108, 32'h0000_0108, 0);

        // Memory error on third beat: burst abandoned, upstream error, line stays invalid
        clear_mon();
        err_en = 1'b1; err_addr = 32'h0000_0408;
        err_chk("fill_err", 32'h0000_0400, 1'b0, 3'b010, 6);
        check("fill_err_beats", acc_addr.size(), 32'd3);
        err_en = 1'b0;
        rd_chk("fill_err_retry", 32'h0000_0400, 32'h0000_0400, 6);

        // Reset in the middle of a fill drops the burst at once
        s_hsel = 1'b1; s_haddr = 32'h0000_0504; s_htrans = 2'b10; s_hwrite = 1'b0;
        @(posedge hclk); #1;
        s_hsel = 1'b0; s_htrans = 2'b00;
        @(posedge hclk); @(posedge hclk); #1;
        check("midfill_busy", {30'd0, m_htrans}, 32'd3);
        hrst = 1'b0;
        #1;
        check("midrst_mtrans", {30'd0, m_htrans}, 32'd0);
        check("midrst_ready", {31'd0, s_hreadyout}, 32'd1);
        check("midrst_mburst", {29'd0, m_hburst}, 32'd0);
        @(negedge hclk);
        hrst = 1'b1;
        @(posedge hclk); #1;
        rd_chk("post_rst_miss", 32'h0000_0504, 32'h0000_0504, 6);
        rd_chk("post_rst_cold", 32'h0000_031C, 32'h0000_031C, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
